// File: rtl/xor_session_ctrl_pkg.sv
// Shared types and defaults for the XOR session controller.
// Holds the controller state encoding, the registered output flag bundle
// and a decode helper that maps a state onto its datapath flags.
package xor_pkg;

  localparam int XOR_KEY_BITS = 8;
  localparam int XOR_MSG_BITS = 64;
  localparam int XOR_TIMEOUT  = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_MSG = 3'd2,
    ST_ENCRYPT  = 3'd3,
    ST_STREAM   = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } xor_ctrl_state_t;

  typedef struct packed {
    logic en;
    logic load_key;
    logic load_msg;
    logic busy;
    logic done;
  } xor_ctrl_flags_t;

  // Flags the datapath should see while the controller sits in state s.
  function automatic xor_ctrl_flags_t state_flags(input xor_ctrl_state_t s);
    xor_ctrl_flags_t f;
    f.en       = (s == ST_LOAD_KEY) || (s == ST_LOAD_MSG) ||
                 (s == ST_ENCRYPT)  || (s == ST_STREAM);
    f.load_key = (s == ST_LOAD_KEY);
    f.load_msg = (s == ST_LOAD_MSG);
    f.busy     = (s != ST_IDLE);
    f.done     = (s == ST_DONE);
    return f;
  endfunction

endpackage

// File: rtl/xor_session_ctrl_timer.sv
// xor_ctrl_timer: saturating watchdog counter.
// Counts enabled cycles since the last clear. oExpired is high during the
// enabled cycle on whose closing edge the count reaches TIMEOUT_CYCLES, so a
// wait guarded by this timer lasts at most TIMEOUT_CYCLES cycles.
module xor_ctrl_timer
  import xor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = XOR_TIMEOUT
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iClear,
  input  logic iEnable,
  output logic oExpired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, holding at the maximum; clear has priority.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_count <= '0;
    end else if (iClear) begin
      r_count <= '0;
    end else if (iEnable && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign oExpired = iEnable && (r_count >= CNT_LAST);

endmodule

// File: rtl/xor_session_ctrl.sv
// xor_session_ctrl: session sequencer for the serial XOR encryption datapath.
// Walks key load, message load, encryption and serial readout, watching the
// encryption and serializer status with watchdog timeouts.
// Optional feature macro: XOR_CTRL_KEY_REUSE_EN adds iReuse_key, letting a
// session skip key load and reuse the key already held by the datapath.
module xor_session_ctrl
  import xor_pkg::*;
#(
  parameter int KEY_BITS       = XOR_KEY_BITS,
  parameter int MSG_BITS       = XOR_MSG_BITS,
  parameter int TIMEOUT_CYCLES = XOR_TIMEOUT
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
`ifdef XOR_CTRL_KEY_REUSE_EN
  input  logic       iReuse_key,
`endif
  input  logic       iEnc_done,
  input  logic       iSer_flag,
  output logic       oEn,
  output logic       oLoad_key,
  output logic       oLoad_msg,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic [2:0] oState
);

  localparam int BIT_W = $clog2(MSG_BITS) + 1;
  localparam logic [BIT_W-1:0] KEY_LAST = BIT_W'(KEY_BITS - 1);
  localparam logic [BIT_W-1:0] MSG_LAST = BIT_W'(MSG_BITS - 1);
  localparam logic [BIT_W-1:0] MSG_FULL = BIT_W'(MSG_BITS);

  xor_ctrl_state_t  r_state;
  xor_ctrl_state_t  w_state_nxt;
  xor_ctrl_flags_t  r_flags;
  xor_ctrl_flags_t  w_flags;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_enc_done;
  logic             r_error;
  logic             w_state_chg;
  logic             w_timer_en;
  logic             w_expired;
  logic             w_ser_active;
  logic             w_reuse_key;

`ifdef XOR_CTRL_KEY_REUSE_EN
  assign w_reuse_key = iReuse_key;
`else
  assign w_reuse_key = 1'b0;
`endif

  // In STREAM the bit counter only moves once the serializer flag has risen,
  // so a non-zero count marks the flag-high (counting) phase.
  assign w_ser_active = (r_bit_cnt != '0);
  assign w_state_chg  = (w_state_nxt != r_state);
  assign w_timer_en   = (r_state == ST_ENCRYPT) ||
                        ((r_state == ST_STREAM) && !w_ser_active);

  xor_ctrl_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .iClk     (iClk),
    .iRst     (iRst),
    .iClear   (w_state_chg),
    .iEnable  (w_timer_en),
    .oExpired (w_expired)
  );

  // State register.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the flags the next state will drive.
  // NOTE: every signal gets a default before the case so no path can leave
  // it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_state_nxt = w_reuse_key ? ST_LOAD_MSG : ST_LOAD_KEY;
        end
      end
      ST_LOAD_KEY: begin
        if (r_bit_cnt == KEY_LAST) begin
          w_state_nxt = ST_LOAD_MSG;
        end
      end
      ST_LOAD_MSG: begin
        if (r_bit_cnt == MSG_LAST) begin
          w_state_nxt = ST_ENCRYPT;
        end
      end
      ST_ENCRYPT: begin
        // Success is checked first so it wins over a same-cycle timeout.
        if (r_enc_done) begin
          w_state_nxt = ST_STREAM;
        end else if (w_expired) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_STREAM: begin
        if (!w_ser_active) begin
          // Waiting for the flag to rise; a rise on the last allowed cycle
          // still counts as in time.
          if (!iSer_flag && w_expired) begin
            w_state_nxt = ST_ERROR;
          end
        end else if (iSer_flag) begin
          if (r_bit_cnt == MSG_FULL) begin
            w_state_nxt = ST_ERROR;
          end
        end else begin
          w_state_nxt = (r_bit_cnt == MSG_FULL) ? ST_DONE : ST_ERROR;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERROR: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_flags = state_flags(w_state_nxt);
  end

  // Bit counter: counts load cycles and flag-high stream cycles, cleared on
  // every state change.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_bit_cnt <= '0;
    end else if (w_state_chg) begin
      r_bit_cnt <= '0;
    end else if ((r_state == ST_LOAD_KEY) || (r_state == ST_LOAD_MSG) ||
                 ((r_state == ST_STREAM) && iSer_flag)) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Registered outputs, encryption status sample and the sticky error flag.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_flags    <= '0;
      r_enc_done <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_flags    <= w_flags;
      // Only sampled inside ENCRYPT so a stale status from a previous
      // session cannot skip the wait.
      r_enc_done <= iEnc_done && (r_state == ST_ENCRYPT);
      if ((r_state == ST_IDLE) && iStart) begin
        r_error <= 1'b0;
      end else if (w_state_nxt == ST_ERROR) begin
        r_error <= 1'b1;
      end
    end
  end

  assign oEn       = r_flags.en;
  assign oLoad_key = r_flags.load_key;
  assign oLoad_msg = r_flags.load_msg;
  assign oBusy     = r_flags.busy;
  assign oDone     = r_flags.done;
  assign oError    = r_error;
  assign oState    = r_state;

endmodule

// File: tb/tb_xor_session_ctrl.sv
// Self-checking bench for xor_session_ctrl at default parameters.
// A session model turns each directed scenario into an expected per-cycle
// state timeline; one compare process checks every output against it on each
// falling edge, and per-session literal totals pin the model itself.
// Build with XOR_CTRL_KEY_REUSE_EN defined to also cover the key-reuse path.
module tb_xor_session_ctrl;

  localparam int KEY = 8;
  localparam int MSG = 64;
  localparam int TMO = 255;

  localparam int S_IDLE = 0, S_LKEY = 1, S_LMSG = 2, S_ENC = 3,
                 S_STR = 4, S_DONE = 5, S_ERR = 6;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iStart;
  logic       iEnc_done;
  logic       iSer_flag;
`ifdef XOR_CTRL_KEY_REUSE_EN
  logic       iReuse_key;
`endif
  logic       oEn, oLoad_key, oLoad_msg, oBusy, oDone, oError;
  logic [2:0] oState;

  always #5 iClk = ~iClk;

  xor_session_ctrl dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iStart     (iStart),
`ifdef XOR_CTRL_KEY_REUSE_EN
    .iReuse_key (iReuse_key),
`endif
    .iEnc_done  (iEnc_done),
    .iSer_flag  (iSer_flag),
    .oEn        (oEn),
    .oLoad_key  (oLoad_key),
    .oLoad_msg  (oLoad_msg),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oError     (oError),
    .oState     (oState)
  );

  int n_checks = 0;
  int n_err    = 0;

  int exp_state = S_IDLE;
  bit exp_err   = 1'b0;
  bit chk_en    = 1'b0;
  int cyc       = 0;

  int cnt_key, cnt_msg, cnt_enc, cnt_str, cnt_done, first_enc;

  int tl[$];
  int tl_enc_start;
  int tl_str_start;
  bit tl_stream;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Session model: expected state for each cycle after the iStart cycle.
  // enc_k: ENCRYPT cycle index carrying iEnc_done (-1 = never).
  // ser_s: STREAM cycle index where the flag rises; ser_len: cycles high.
  function automatic void build_timeline(input bit reuse, input int enc_k,
                                         input int ser_s, input int ser_len);
    int n;
    tl.delete();
    if (!reuse) for (int i = 0; i < KEY; i++) tl.push_back(S_LKEY);
    for (int i = 0; i < MSG; i++) tl.push_back(S_LMSG);
    tl_enc_start = 1 + tl.size();
    // Status is seen one cycle after it is driven; the wait allows TMO cycles.
    tl_stream = (enc_k >= 0) && (enc_k + 1 <= TMO - 1);
    n = tl_stream ? enc_k + 2 : TMO;
    for (int i = 0; i < n; i++) tl.push_back(S_ENC);
    tl_str_start = 1 + tl.size();
    if (!tl_stream) begin
      tl.push_back(S_ERR);
    end else if (ser_len > 0 && ser_s <= TMO - 1) begin
      n = ser_s + ((ser_len < MSG) ? ser_len : MSG) + 1;
      for (int i = 0; i < n; i++) tl.push_back(S_STR);
      tl.push_back((ser_len == MSG) ? S_DONE : S_ERR);
    end else begin
      for (int i = 0; i < TMO; i++) tl.push_back(S_STR);
      tl.push_back(S_ERR);
    end
    tl.push_back(S_IDLE);
    tl.push_back(S_IDLE);
  endfunction

  // Compare process: every output against the model, every cycle.
  always @(negedge iClk) begin
    if (chk_en) begin
      check("state",    oState,    exp_state);
      check("en",       oEn,       (exp_state >= S_LKEY && exp_state <= S_STR) ? 1 : 0);
      check("load_key", oLoad_key, (exp_state == S_LKEY) ? 1 : 0);
      check("load_msg", oLoad_msg, (exp_state == S_LMSG) ? 1 : 0);
      check("busy",     oBusy,     (exp_state != S_IDLE) ? 1 : 0);
      check("done",     oDone,     (exp_state == S_DONE) ? 1 : 0);
      check("error",    oError,    exp_err);
      if (oLoad_key === 1'b1) cnt_key++;
      if (oLoad_msg === 1'b1) cnt_msg++;
      if (oDone === 1'b1) cnt_done++;
      if (oState === 3'd4) cnt_str++;
      if (oState === 3'd3) begin
        cnt_enc++;
        if (first_enc < 0) first_enc = cyc;
      end
    end
  end

  // Runs one session starting in an IDLE cycle (called #1 after a rising
  // edge). abort_at >= 0 pulls reset in that cycle instead of finishing.
  task automatic run_session(input bit reuse, input int enc_k, input int ser_s,
                             input int ser_len, input int abort_at,
                             input int w_key, input int w_entry, input int w_enc,
                             input int w_str, input int w_done, input int w_err);
    int last;
    build_timeline(reuse, enc_k, ser_s, ser_len);
    cnt_key = 0; cnt_msg = 0; cnt_enc = 0; cnt_str = 0; cnt_done = 0;
    first_enc = -1;
    cyc = 0;
    exp_state = S_IDLE;
    iStart = 1'b1;
`ifdef XOR_CTRL_KEY_REUSE_EN
    iReuse_key = reuse;
`endif
    last = tl.size();
    if (tl_stream && (tl_str_start + ser_s + ser_len > last))
      last = tl_str_start + ser_s + ser_len;
    for (int c = 1; c <= last; c++) begin
      @(posedge iClk);
      #1;
      cyc = c;
      exp_state = (c <= tl.size()) ? tl[c-1] : S_IDLE;
      if (c == 1) exp_err = 1'b0;
      if (exp_state == S_ERR) exp_err = 1'b1;
      iStart    = (c == 20);  // mid-session request, must be ignored
      iEnc_done = (enc_k >= 0) && (c == tl_enc_start + enc_k);
      iSer_flag = tl_stream && (c >= tl_str_start + ser_s) &&
                  (c < tl_str_start + ser_s + ser_len);
      if (c == abort_at) begin
        #1 iRst = 1'b0;
        exp_state = S_IDLE;
        exp_err   = 1'b0;
        #1;
        check("rst_state",    oState,    0);
        check("rst_en",       oEn,       0);
        check("rst_load_key", oLoad_key, 0);
        check("rst_load_msg", oLoad_msg, 0);
        check("rst_busy",     oBusy,     0);
        iStart = 1'b0; iEnc_done = 1'b0; iSer_flag = 1'b0;
        @(negedge iClk);
        #2 iRst = 1'b1;
        @(posedge iClk);
        #1;
        return;
      end
    end
    iStart = 1'b0; iEnc_done = 1'b0; iSer_flag = 1'b0;
    check("key_cycles",  cnt_key,   w_key);
    check("msg_cycles",  cnt_msg,   MSG);
    check("enc_entry",   first_enc, w_entry);
    check("enc_cycles",  cnt_enc,   w_enc);
    check("str_cycles",  cnt_str,   w_str);
    check("done_pulses", cnt_done,  w_done);
    check("err_at_end",  oError,    w_err);
  endtask

  initial begin
    iRst = 1'b0; iStart = 1'b0; iEnc_done = 1'b0; iSer_flag = 1'b0;
`ifdef XOR_CTRL_KEY_REUSE_EN
    iReuse_key = 1'b0;
`endif
    repeat (3) @(posedge iClk);
    #1;
    check("reset_state",    oState,    0);
    check("reset_en",       oEn,       0);
    check("reset_load_key", oLoad_key, 0);
    check("reset_load_msg", oLoad_msg, 0);
    check("reset_busy",     oBusy,     0);
    check("reset_done",     oDone,     0);
    check("reset_error",    oError,    0);
    @(negedge iClk);
    #2 iRst = 1'b1;
    @(posedge iClk);
    #1;
    chk_en = 1'b1;

    //           reuse enc_k ser_s len abort  key entry enc  str done err
    run_session(0,    3,    2,    64, -1,    8,  73,   5,   67,  1,  0); // nominal
    run_session(0,   -1,    0,    64, -1,    8,  73, 255,    0,  0,  1); // enc timeout
    run_session(0,  253,    0,    64, -1,    8,  73, 255,   65,  1,  0); // done on last cycle
    run_session(0,  254,    0,    64, -1,    8,  73, 255,    0,  0,  1); // done too late
    run_session(0,    3,    1,    63, -1,    8,  73,   5,   65,  0,  1); // short stream
    run_session(0,    0,    0,    70, -1,    8,  73,   2,   65,  0,  1); // overlong stream
    run_session(0,    3,    0,     0, -1,    8,  73,   5,  255,  0,  1); // flag never rises
    run_session(0,    3,  254,    64, -1,    8,  73,   5,  319,  1,  0); // late rise in time
    run_session(0,    3,    2,    64, 39,    0,   0,   0,    0,  0,  0); // reset at msg bit 30
    run_session(0,    3,    2,    64, -1,    8,  73,   5,   67,  1,  0); // restart after reset
`ifdef XOR_CTRL_KEY_REUSE_EN
    run_session(1,    3,    2,    64, -1,    0,  65,   5,   67,  1,  0); // key reuse
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xor_session_ctrl.md
# xor_session_ctrl

Session sequencer for the serial XOR encryption datapath. Accepts a start pulse from the host and drives the datapath's enable and load flags through key load, message load, encryption and serial readout. Monitors encryption and serializer status with watchdog timeouts, then reports done or error. Sits between the chip-level pin logic and the XOR datapath top; the datapath's own serial input is fed directly from the pin.

## Interface
Parameters:
- KEY_BITS, 8, key length in bits; must match the key deserializer.
- MSG_BITS, 64, message length in bits; must match the message deserializer and serializer.
- TIMEOUT_CYCLES, 255, maximum wait in ENCRYPT, and maximum wait for the serializer flag to rise.

Ports:
- iClk  in  1  single clock; all logic on the rising edge.
- iRst  in  1  asynchronous, active-low reset.
- iStart  in  1  session request; sampled only in IDLE.
- iEnc_done  in  1  encryption status from the datapath.
- iSer_flag  in  1  serializer output-valid flag from the datapath.
- oEn  out  1  datapath enable.
- oLoad_key  out  1  key load flag to the datapath.
- oLoad_msg  out  1  message load flag to the datapath.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle pulse on successful completion.
- oError  out  1  sticky error; cleared only by the next accepted iStart or by reset.
- oState  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, LOAD_KEY=1, LOAD_MSG=2, ENCRYPT=3, STREAM=4, DONE=5, ERROR=6.
- IDLE:
  - iStart=1 moves to LOAD_KEY and clears oError.
- LOAD_KEY:
  - oLoad_key=1 and oEn=1 for exactly KEY_BITS cycles; the bit counter counts 0..KEY_BITS-1.
  - Moves to LOAD_MSG after the cycle where the count equals KEY_BITS-1.
- LOAD_MSG:
  - oLoad_msg=1 and oEn=1 for exactly MSG_BITS cycles.
  - Then moves to ENCRYPT.
- ENCRYPT:
  - oEn=1; waits for iEnc_done=1, then moves to STREAM.
  - If the timeout counter reaches TIMEOUT_CYCLES first, moves to ERROR.
- STREAM:
  - Phase 1: waits up to TIMEOUT_CYCLES for iSer_flag to rise.
  - Phase 2: counts the cycles iSer_flag is high.
  - iSer_flag falling with count==MSG_BITS moves to DONE.
  - Any of these moves to ERROR:
    - flag falls early;
    - flag is still high after MSG_BITS cycles;
    - phase-1 timeout.
- DONE: oDone=1 for one cycle, then IDLE.
- ERROR: oError set; one cycle later moves to IDLE, with oError held.
- oLoad_key and oLoad_msg are never high together. oEn=0 in IDLE, DONE and ERROR.
- Counter widths:
  - bit counter is $clog2(MSG_BITS)+1 bits;
  - timeout counter is $clog2(TIMEOUT_CYCLES+1) bits, saturating.
  - Both clear on every state change.

## Timing
- Reset values: all outputs 0, oState=IDLE, all counters 0.
- Asserting iRst mid-session immediately forces IDLE with every output at 0. No partial session resumes.
- Outputs are registered. oLoad_key rises on the edge that samples iStart=1.
  - The host drives key bit 0 in that first oLoad_key-high cycle.
  - Key bits are MSB-first per the deserializer convention.
- LOAD_MSG starts on the cycle immediately after the last LOAD_KEY cycle. There is no gap cycle.
- Fixed latency from iStart to entering ENCRYPT: 1+KEY_BITS+MSG_BITS cycles (73 at defaults).
- iEnc_done is sampled registered; ENCRYPT to STREAM takes 1 cycle after iEnc_done is seen.
- iStart outside IDLE is ignored. iStart held high in DONE or ERROR starts a new session on the cycle after returning to IDLE.
- Simultaneous timeout expiry and iEnc_done in the same cycle: success wins.

## Configuration
- XOR_CTRL_KEY_REUSE_EN defined:
  - adds input port iReuse_key (1 bit);
  - iStart with iReuse_key=1 goes IDLE to LOAD_MSG directly, keeping the previously loaded key;
  - latency to ENCRYPT becomes 1+MSG_BITS.
- Macro undefined: no iReuse_key port, and every session loads the key.

## Structure
- Shared package xor_pkg holds:
  - the state enum xor_ctrl_state_t with the fixed encodings above;
  - default constants XOR_KEY_BITS=8, XOR_MSG_BITS=64, XOR_TIMEOUT=255.
- One sub-module, xor_ctrl_timer: saturating timeout counter with clear and enable inputs and an expired output. Reused for the ENCRYPT wait and the STREAM phase-1 wait.

## Test plan
- Nominal session:
  - stimulus: iStart pulse; iEnc_done at ENCRYPT cycle 3; iSer_flag high for 64 cycles;
  - required: oLoad_key high 8 cycles, oLoad_msg high 64, oDone pulse, oError=0, back to IDLE.
- Encryption timeout:
  - stimulus: iEnc_done never asserted;
  - required: ERROR after 255 cycles in ENCRYPT, oError=1 and held in IDLE, cleared by the next iStart.
- Short stream:
  - stimulus: iSer_flag high only 63 cycles;
  - required: ERROR, no oDone.
- Overlong stream:
  - stimulus: iSer_flag high 65+ cycles;
  - required: ERROR at count 64.
- Reset mid-LOAD_MSG:
  - stimulus: iRst low at message bit 30;
  - required: all outputs 0 on that cycle and state IDLE; a new iStart restarts from LOAD_KEY.
- With XOR_CTRL_KEY_REUSE_EN:
  - stimulus: iStart with iReuse_key=1;
  - required: oLoad_key never rises, oLoad_msg rises on the next edge, and ENCRYPT is entered at cycle 65.
